// File: rtl/serial_tx_pkg.sv
// Shared types and sizing helpers for the chunked serial transmitter.
// Chunk count and counter width are derived from the word and chunk widths.
package serial_tx_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } txState_t;

    function automatic int chunks(int dinLength, int size);
        return dinLength / size;
    endfunction

    function automatic int cntWidth(int dinLength, int size);
        int c;
        c = chunks(dinLength, size);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic bit sizeOk(int dinLength, int size);
        return (size > 0) && (dinLength % size == 0);
    endfunction

endpackage

// File: rtl/serial_chunk_tx_if.sv
// Word input and chunk output bundle of the serial transmitter.
// The capture side is the master; the transmitter is the slave.
interface serial_chunk_tx_if #(
    parameter int DinLENGTH = 32,
    parameter int SIZE      = 4
);
    logic [DinLENGTH-1:0] DataIn;
    logic                 SampleData;
    logic [SIZE-1:0]      DataOut;
    logic                 DataValid;
    logic                 TxDone;

    modport master (
        output DataIn, SampleData,
        input  DataOut, DataValid, TxDone
    );

    modport slave (
        input  DataIn, SampleData,
        output DataOut, DataValid, TxDone
    );
endinterface

// File: rtl/serial_tx_fifo.sv
// Synchronous word FIFO with registered Level/Full/Empty and overflow pulse.
// Flush wins over push and pop and never raises Overflow.
module serial_tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Push,
    input  logic             Pop,
    input  logic             Flush,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] RdData,
    output logic             Full,
    output logic             Empty,
    output logic             Overflow,
    output logic [LW-1:0]    Level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;
    logic [LW-1:0]    levelNext;

    assign doPush    = Push && !Full && !Flush;
    assign doPop     = Pop && !Empty && !Flush;
    assign levelNext = Level + LW'(doPush) - LW'(doPop);
    assign RdData    = mem[rdPtr];

    always_ff @(posedge Clk) begin
        if (doPush) begin
            mem[wrPtr] <= WrData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Level    <= '0;
            Full     <= 1'b0;
            Empty    <= 1'b1;
            Overflow <= 1'b0;
        end else if (Flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            Level    <= '0;
            Full     <= 1'b0;
            Empty    <= 1'b1;
            Overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            Level    <= levelNext;
            Full     <= (levelNext == LW'(DEPTH));
            Empty    <= (levelNext == '0);
            Overflow <= Push && Full;
        end
    end

endmodule

// File: rtl/serial_chunk_tx.sv
// Chunked serial transmitter: FIFO-buffered words shifted out SIZE bits
// per TxTick, with back-to-back reload and synchronous flush.
module serial_chunk_tx
    import serial_tx_pkg::*;
#(
    parameter int DinLENGTH = 32,
    parameter int SIZE      = 4,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    serial_chunk_tx_if.slave             bus,
    input  logic                         StartTx,
    input  logic                         TxTick,
    input  logic                         Flush,
    output logic                         TxBusy,
    output logic                         Full,
    output logic                         Empty,
    output logic                         Overflow,
    output logic [$clog2(DEPTH+1)-1:0]   Level
);

    localparam int CHUNKS = chunks(DinLENGTH, SIZE);
    localparam int CW     = cntWidth(DinLENGTH, SIZE);

    if (!sizeOk(DinLENGTH, SIZE)) begin : gSizeCheck
        $error("DinLENGTH must be a multiple of SIZE");
    end

    txState_t             state;
    txState_t             stateNext;
    logic [DinLENGTH-1:0] shifter;
    logic [DinLENGTH-1:0] shiftNext;
    logic [DinLENGTH-1:0] head;
    logic [CW-1:0]        cnt;
    logic [SIZE-1:0]      chunkNow;
    logic [SIZE-1:0]      dataOut;
    logic                 dataValid;
    logic                 txDone;
    logic                 popReq;
    logic                 load;
    logic                 emit;
    logic                 last;

    serial_tx_fifo #(
        .WIDTH (DinLENGTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .Reset    (Reset),
        .Push     (bus.SampleData),
        .Pop      (popReq),
        .Flush    (Flush),
        .WrData   (bus.DataIn),
        .RdData   (head),
        .Full     (Full),
        .Empty    (Empty),
        .Overflow (Overflow),
        .Level    (Level)
    );

    assign chunkNow  = MSB_FIRST ? shifter[DinLENGTH-1 -: SIZE]
                                 : shifter[SIZE-1:0];
    assign shiftNext = MSB_FIRST ? (shifter << SIZE) : (shifter >> SIZE);

    assign TxBusy        = (state == SHIFT);
    assign bus.DataOut   = dataOut;
    assign bus.DataValid = dataValid;
    assign bus.TxDone    = txDone;

    always_comb begin
        stateNext = state;
        popReq    = 1'b0;
        load      = 1'b0;
        emit      = 1'b0;
        last      = 1'b0;
        if (Flush) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (StartTx && !Empty) begin
                        popReq    = 1'b1;
                        load      = 1'b1;
                        stateNext = SHIFT;
                    end
                end
                SHIFT: begin
                    if (TxTick) begin
                        emit = 1'b1;
                        if (cnt == CW'(CHUNKS - 1)) begin
                            last = 1'b1;
                            // Reload on the final tick keeps words gapless
                            if (StartTx && !Empty) begin
                                popReq = 1'b1;
                                load   = 1'b1;
                            end else begin
                                stateNext = IDLE;
                            end
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            shifter   <= '0;
            cnt       <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            txDone    <= 1'b0;
        end else begin
            state     <= stateNext;
            dataValid <= emit;
            txDone    <= last;
            if (emit) begin
                dataOut <= chunkNow;
            end
            if (load) begin
                shifter <= head;
                cnt     <= '0;
            end else if (emit) begin
                shifter <= shiftNext;
                cnt     <= cnt + CW'(1);
            end
        end
    end

endmodule
